// File: rtl/serial_operand_sequencer_pkg.sv
// serial_cpu_pkg: shared state and ALU function codes for the serial ALU front/back end.
package serial_cpu_pkg;
  typedef enum logic [1:0] {IDLE, PRIME, SHIFT, CAPTURE} seq_state_t;
  localparam logic [2:0] FUNC_CLR   = 3'b000;
  localparam logic [2:0] FUNC_SET   = 3'b001;
  localparam logic [2:0] FUNC_ADD   = 3'b010;
  localparam logic [2:0] FUNC_CARRY = 3'b110;
endpackage

// File: rtl/serial_operand_sequencer_if.sv
// serial_operand_sequencer_if: parallel operand request and result handshake.
interface serial_operand_sequencer_if #(parameter int WIDTH = 8);
  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [2:0]       op_func;
  logic             carry_init;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  modport master (output start, op_a, op_b, op_func, carry_init,
                  input busy, done, result, carry_out);
  modport slave  (input start, op_a, op_b, op_func, carry_init,
                  output busy, done, result, carry_out);
endinterface

// File: rtl/serial_operand_sequencer_shift_reg.sv
// serial_shift_reg: right-shifting register with parallel load and serial in/out.
module serial_shift_reg #(parameter int WIDTH = 8) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_shift,
  input  logic             i_sin,
  output logic             o_sout,
  output logic [WIDTH-1:0] o_q
);
  logic [WIDTH-1:0] r_q;
  always_ff @(posedge clk) begin
    if (rst) r_q <= '0;
    else if (i_load) r_q <= i_data;
    else if (i_shift) r_q <= {i_sin, r_q[WIDTH-1:1]};
  end
  assign o_sout = r_q[0];
  assign o_q = r_q;
endmodule

// File: rtl/serial_operand_sequencer.sv
// serial_operand_sequencer: streams operands LSB-first into a bit-serial ALU and reassembles the result.
module serial_operand_sequencer
  import serial_cpu_pkg::*;
#(parameter int WIDTH = 8) (
  input  logic clk,
  input  logic rst,
  serial_operand_sequencer_if.slave bus,
  output logic       alu_a,
  output logic       alu_b,
  output logic [2:0] alu_func,
  input  logic       alu_out,
  input  logic       alu_c_out
);
  localparam int CW = $clog2(WIDTH);
  seq_state_t       r_state, w_next;
  logic [CW-1:0]    r_cnt;
  logic [2:0]       r_func;
  logic             r_cin, r_done, r_cout;
  logic [WIDTH-1:0] r_result;
  logic             w_accept, w_shift, w_last;
  logic             w_a_sout, w_b_sout, w_r_sout;
  logic [WIDTH-1:0] w_a_q, w_b_q, w_res_q;
  logic             w_unused;
  assign w_accept = (r_state == IDLE) && bus.start;
  assign w_shift  = (r_state == SHIFT);
  assign w_last   = (r_cnt == CW'(WIDTH - 1));
  assign w_unused = &{1'b0, w_a_q, w_b_q, w_r_sout};
  serial_shift_reg #(.WIDTH(WIDTH)) u_a (
    .clk(clk), .rst(rst), .i_load(w_accept), .i_data(bus.op_a), .i_shift(w_shift),
    .i_sin(1'b0), .o_sout(w_a_sout), .o_q(w_a_q));
  serial_shift_reg #(.WIDTH(WIDTH)) u_b (
    .clk(clk), .rst(rst), .i_load(w_accept), .i_data(bus.op_b), .i_shift(w_shift),
    .i_sin(1'b0), .o_sout(w_b_sout), .o_q(w_b_q));
  serial_shift_reg #(.WIDTH(WIDTH)) u_res (
    .clk(clk), .rst(rst), .i_load(w_accept), .i_data('0), .i_shift(w_shift),
    .i_sin(alu_out), .o_sout(w_r_sout), .o_q(w_res_q));
  always_comb begin
    w_next   = r_state;
    alu_a    = 1'b0;
    alu_b    = 1'b0;
    alu_func = FUNC_CLR;
    case (r_state)
      IDLE:    w_next = bus.start ? PRIME : IDLE;
      PRIME: begin
        alu_func = r_cin ? FUNC_SET : FUNC_CLR;
        w_next   = SHIFT;
      end
      SHIFT: begin
        alu_a    = w_a_sout;
        alu_b    = w_b_sout;
        alu_func = r_func;
        w_next   = w_last ? CAPTURE : SHIFT;
      end
      CAPTURE: begin
        alu_func = r_func;
        w_next   = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end
  // result/carry_out only move at CAPTURE so partial sums never leak out
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_func   <= FUNC_CLR;
      r_cin    <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_cout   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= (r_state == CAPTURE);
      if (w_accept) begin
        r_func <= bus.op_func;
        r_cin  <= bus.carry_init;
        r_cnt  <= '0;
      end
      if (w_shift && !w_last) r_cnt <= r_cnt + 1'b1;
      if (r_state == CAPTURE) begin
        r_result <= w_res_q;
        r_cout   <= alu_c_out;
      end
    end
  end
  assign bus.busy      = (r_state != IDLE);
  assign bus.done      = r_done;
  assign bus.result    = r_result;
  assign bus.carry_out = r_cout;
endmodule
